// File: rtl/a_skew_feeder.sv
// Streams matrix A from array_mem_A into the four west-edge rows of the systolic array.
// Row r lags row 0 by r cycles so the PEs see a diagonal wavefront.
module a_skew_feeder #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned ROW_STRIDE = 16,
  parameter int unsigned MAX_K      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        k_len,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_addr_0,
  output logic [ADDR_W-1:0] read_addr_1,
  output logic [ADDR_W-1:0] read_addr_2,
  output logic [ADDR_W-1:0] read_addr_3,
  input  logic [DATA_W-1:0] read_data_0,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] read_data_3,
  output logic [DATA_W-1:0] a_out_0,
  output logic [DATA_W-1:0] a_out_1,
  output logic [DATA_W-1:0] a_out_2,
  output logic [DATA_W-1:0] a_out_3,
  output logic              a_valid_0,
  output logic              a_valid_1,
  output logic              a_valid_2,
  output logic              a_valid_3
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [4:0]        t, t_next;
  logic [4:0]        k_reg, k_next;
  logic [4:0]        k_clip;
  logic              done_q, done_next;
  logic              load, clear;
  logic [3:0]        active;
  logic [ADDR_W-1:0] addr  [4];
  logic [DATA_W-1:0] rdata [4];
  logic [DATA_W-1:0] a_q   [4];
  logic [3:0]        valid_q;

  assign k_clip = (k_len > 5'(MAX_K)) ? 5'(MAX_K) : k_len;

  assign rdata[0] = read_data_0;
  assign rdata[1] = read_data_1;
  assign rdata[2] = read_data_2;
  assign rdata[3] = read_data_3;

  // Row r is live for steps r..r+K-1; idle rows park on their row base address.
  always_comb begin
    active = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      active[r] = (state == RUN) && ({1'b0, t} >= 6'(r)) &&
                  ({1'b0, t} < (6'(r) + {1'b0, k_reg}));
      addr[r]   = ADDR_W'(r * ROW_STRIDE) + (active[r] ? ADDR_W'(t - 5'(r)) : '0);
    end
  end

  always_comb begin
    state_next = state;
    t_next     = t;
    k_next     = k_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    clear      = 1'b0;
    unique case (state)
      IDLE: begin
        clear = 1'b1;
        if (start) begin
          k_next = k_clip;
          t_next = '0;
          if (k_clip != '0) state_next = RUN;
          else              done_next  = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          load   = 1'b1;
          t_next = t + 5'd1;
          if (t == k_reg + 5'd2) begin
            state_next = IDLE;
            t_next     = '0;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      t       <= '0;
      k_reg   <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
      for (int unsigned r = 0; r < 4; r++) a_q[r] <= '0;
    end else begin
      state  <= state_next;
      t      <= t_next;
      k_reg  <= k_next;
      done_q <= done_next;
      for (int unsigned r = 0; r < 4; r++) begin
        if (clear) begin
          a_q[r]     <= '0;
          valid_q[r] <= 1'b0;
        end else if (load) begin
          a_q[r]     <= active[r] ? rdata[r] : '0;
          valid_q[r] <= active[r];
        end
      end
    end
  end

  assign busy        = (state == RUN);
  assign done        = done_q;
  assign read_addr_0 = addr[0];
  assign read_addr_1 = addr[1];
  assign read_addr_2 = addr[2];
  assign read_addr_3 = addr[3];
  assign a_out_0     = a_q[0];
  assign a_out_1     = a_q[1];
  assign a_out_2     = a_q[2];
  assign a_out_3     = a_q[3];
  assign a_valid_0   = valid_q[0];
  assign a_valid_1   = valid_q[1];
  assign a_valid_2   = valid_q[2];
  assign a_valid_3   = valid_q[3];

endmodule

// File: tb/tb_a_skew_feeder.sv
// Self-checking bench for a_skew_feeder: directed vector table, corner sequences,
// and randomized traffic against a queue-of-beats reference model.
module tb_a_skew_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  k_len = '0;
  logic        stall = 1'b0;
  logic        busy, done;
  logic [5:0]  ra   [4];
  logic [15:0] rd   [4];
  logic [15:0] aout [4];
  logic [3:0]  av;
  logic [15:0] mem  [64];

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mem
    assign rd[g] = mem[ra[g]];
  end

  a_skew_feeder #(.DATA_W(16), .ADDR_W(6), .ROW_STRIDE(16), .MAX_K(16)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall),
    .busy(busy), .done(done),
    .read_addr_0(ra[0]), .read_addr_1(ra[1]), .read_addr_2(ra[2]), .read_addr_3(ra[3]),
    .read_data_0(rd[0]), .read_data_1(rd[1]), .read_data_2(rd[2]), .read_data_3(rd[3]),
    .a_out_0(aout[0]), .a_out_1(aout[1]), .a_out_2(aout[2]), .a_out_3(aout[3]),
    .a_valid_0(av[0]), .a_valid_1(av[1]), .a_valid_2(av[2]), .a_valid_3(av[3])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start expands into the full list of K+3 beats,
  // each beat consumed by one non-stalled edge.
  typedef struct {
    logic [3:0]  v;
    logic [15:0] d [4];
    logic [5:0]  a [4];
  } beat_t;

  beat_t       q[$];
  logic        m_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [3:0]  exp_v = '0;
  logic [15:0] exp_d [4] = '{default: '0};

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_busy   = 1'b0;
      exp_done = 1'b0;
      exp_v    = '0;
      for (int r = 0; r < 4; r++) exp_d[r] = '0;
    end else if (!m_busy) begin
      exp_done = 1'b0;
      exp_v    = '0;
      for (int r = 0; r < 4; r++) exp_d[r] = '0;
      if (start) begin
        int kk;
        kk = (int'(k_len) > 16) ? 16 : int'(k_len);
        if (kk == 0) exp_done = 1'b1;
        else begin
          for (int b = 0; b < kk + 3; b++) begin
            beat_t bt;
            for (int r = 0; r < 4; r++) begin
              bt.v[r] = (b >= r) && (b < r + kk);
              bt.a[r] = 6'(r * 16 + (bt.v[r] ? b - r : 0));
              bt.d[r] = bt.v[r] ? mem[bt.a[r]] : 16'd0;
            end
            q.push_back(bt);
          end
          m_busy = 1'b1;
        end
      end
    end else begin
      exp_done = 1'b0;
      if (!stall) begin
        beat_t bt;
        bt    = q.pop_front();
        exp_v = bt.v;
        for (int r = 0; r < 4; r++) exp_d[r] = bt.d[r];
        if (q.size() == 0) begin
          m_busy   = 1'b0;
          exp_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", int'(busy), int'(m_busy));
      chk("m_done", int'(done), int'(exp_done));
      chk("m_valid", int'(av), int'(exp_v));
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("m_aout%0d", r), int'(aout[r]), int'(exp_d[r]));
        if (m_busy && q.size() > 0)
          chk($sformatf("m_addr%0d", r), int'(ra[r]), int'(q[0].a[r]));
      end
    end
  end

  // Apply inputs, take one rising edge, return at the following falling edge.
  task automatic cyc(input logic s, input logic [4:0] kl, input logic st, input logic r);
    start = s; k_len = kl; stall = st; rst = r;
    @(negedge clk);
  endtask

  task automatic wait_done(input int from, output int at);
    at = from;
    while (done !== 1'b1 && at < from + 100) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0);
      at++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic        busy;
    logic        done;
    logic [3:0]  v;
    logic [15:0] o0, o1, o2, o3;
  } vec_t;
  vec_t tbl [9];

  task automatic run_table(input string tag);
    cyc(1'b1, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s_c%0d_busy", tag, i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("%s_c%0d_done", tag, i), int'(done), int'(tbl[i].done));
      chk($sformatf("%s_c%0d_valid", tag, i), int'(av), int'(tbl[i].v));
      chk($sformatf("%s_c%0d_row0", tag, i), int'(aout[0]), int'(tbl[i].o0));
      chk($sformatf("%s_c%0d_row1", tag, i), int'(aout[1]), int'(tbl[i].o1));
      chk($sformatf("%s_c%0d_row2", tag, i), int'(aout[2]), int'(tbl[i].o2));
      chk($sformatf("%s_c%0d_row3", tag, i), int'(aout[3]), int'(tbl[i].o3));
      cyc(1'b0, 5'd0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v4, v19, maxa;

    // Cycle c counts negedges after the start edge (c0 = first RUN cycle, beat t=0 appears at c1).
    tbl[0] = '{1'b1, 1'b0, 4'b0000, 16'd0, 16'd0,  16'd0,  16'd0};
    tbl[1] = '{1'b1, 1'b0, 4'b0001, 16'd1, 16'd0,  16'd0,  16'd0};
    tbl[2] = '{1'b1, 1'b0, 4'b0011, 16'd2, 16'd17, 16'd0,  16'd0};
    tbl[3] = '{1'b1, 1'b0, 4'b0111, 16'd3, 16'd18, 16'd33, 16'd0};
    tbl[4] = '{1'b1, 1'b0, 4'b1111, 16'd4, 16'd19, 16'd34, 16'd49};
    tbl[5] = '{1'b1, 1'b0, 4'b1110, 16'd0, 16'd20, 16'd35, 16'd50};
    tbl[6] = '{1'b1, 1'b0, 4'b1100, 16'd0, 16'd0,  16'd36, 16'd51};
    tbl[7] = '{1'b0, 1'b1, 4'b1000, 16'd0, 16'd0,  16'd0,  16'd52};
    tbl[8] = '{1'b0, 1'b0, 4'b0000, 16'd0, 16'd0,  16'd0,  16'd0};

    for (int i = 0; i < 64; i++) mem[i] = 16'(i + 1);

    @(negedge clk);
    cyc(1'b0, 5'd0, 1'b0, 1'b1);
    cyc(1'b1, 5'd4, 1'b1, 1'b1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_valid", int'(av), 0);
    chk("reset_aout0", int'(aout[0]), 0);
    chk_en = 1'b1;
    cyc(1'b0, 5'd0, 1'b1, 1'b0);
    chk("idle_stall_busy", int'(busy), 0);

    run_table("k4");

    // Two stalled edges after c2 freeze outputs and push done from c7 to c9.
    cyc(1'b1, 5'd4, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    chk("stall_pre_row0", int'(aout[0]), 2);
    chk("stall_pre_row1", int'(aout[1]), 17);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 5'd0, 1'b1, 1'b0);
      chk("stall_row0", int'(aout[0]), 2);
      chk("stall_row1", int'(aout[1]), 17);
      chk("stall_valid", int'(av), 4'b0011);
    end
    wait_done(4, n);
    chk("stall_done_cycle", n, 9);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);

    // Reset mid-stream: no done, then a clean restart.
    cyc(1'b1, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 1'b1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(av), 0);
    chk("abort_done", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0);
      chk("abort_no_done", int'(done), 0);
    end
    run_table("rerun");

    // K=16: row 3 carries 49..64 on c4..c19, address tops out at 63.
    cyc(1'b1, 5'd16, 1'b0, 1'b0);
    n = 0; v4 = -1; maxa = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy && int'(ra[3]) > maxa) maxa = int'(ra[3]);
      if (n == 4) v4 = int'(aout[3]);
      cyc(1'b0, 5'd0, 1'b0, 1'b0);
      n++;
    end
    v19 = int'(aout[3]);
    chk("k16_done_cycle", n, 19);
    chk("k16_row3_first", v4, 49);
    chk("k16_row3_last", v19, 64);
    chk("k16_addr3_max", maxa, 63);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);

    cyc(1'b1, 5'd20, 1'b0, 1'b0);
    wait_done(0, n);
    chk("k20_done_cycle", n, 19);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);

    cyc(1'b1, 5'd0, 1'b0, 1'b0);
    chk("k0_done", int'(done), 1);
    chk("k0_busy", int'(busy), 0);
    chk("k0_valid", int'(av), 0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    chk("k0_done_end", int'(done), 0);

    // start held through the stream is ignored while busy.
    cyc(1'b1, 5'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 5'd4, 1'b0, 1'b0);
    wait_done(5, n);
    chk("held_start_done_cycle", n, 7);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    chk("held_start_idle", int'(busy), 0);

    // Back-to-back: start in the done cycle opens the next stream immediately.
    cyc(1'b1, 5'd4, 1'b0, 1'b0);
    wait_done(0, n);
    chk("b2b_first_done", n, 7);
    cyc(1'b1, 5'd4, 1'b0, 1'b0);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_done_cleared", int'(done), 0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0);
    chk("b2b_row0_first", int'(aout[0]), 1);
    wait_done(1, n);
    chk("b2b_second_done", n, 7);

    // Randomized traffic over fresh memory contents.
    cyc(1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    cyc(1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
